fetch_stage: RTL and testbench

- Instruction-fetch (IF) stage of the 24-bit pipelined processor.
- Holds the program counter and computes the next PC from sequential, branch or writeback-redirect sources.
- Presents PCF to an external combinational instruction memory.
- Latches the returned instruction into the IF/ID pipeline register, steering it to the scalar or vector decode path by its V bit.

---
 rtl/fetch_stage.sv | 75 +++++++
 tb/tb_fetch_stage.sv | 115 +++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter with branch/writeback redirects,
// plus the IF/ID register that steers each fetched word to the scalar or vector decode path.
module fetch_stage #(
  parameter int N = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] ResultW,
  input  logic [N-1:0] ExtImmE,
  input  logic         PCSrcW,
  input  logic         BranchTakenE,
  input  logic         StallF,
  input  logic         StallD,
  input  logic         FlushD,
  input  logic [N-1:0] instruction,
  output logic [N-1:0] PCF,
  output logic [N-1:0] InstrD,
  output logic [N-1:0] InstrD_vector,
  output logic [N-1:0] PCPlus8D
);

  localparam int VBIT = N - 4;

  logic [N-1:0] pc_q, pc_d;
  logic [N-1:0] pc_plus4;
  logic [N-1:0] instr_s_q, instr_s_d;
  logic [N-1:0] instr_v_q, instr_v_d;

  // IF: next-PC selection; an execute-stage branch outranks a writeback redirect
  always_comb begin
    pc_plus4 = pc_q + N'(4);
    pc_d     = pc_q;
    if (StallF) begin
      if (BranchTakenE)  pc_d = ExtImmE;
      else if (PCSrcW)   pc_d = ResultW;
      else               pc_d = pc_plus4;
    end
  end

  // IF/ID: flush inserts the all-zero bubble on both decode paths
  always_comb begin
    instr_s_d = instr_s_q;
    instr_v_d = instr_v_q;
    if (FlushD) begin
      instr_s_d = '0;
      instr_v_d = '0;
    end else if (StallD) begin
      if (instruction[VBIT]) begin
        instr_s_d = '0;
        instr_v_d = instruction;
      end else begin
        instr_s_d = instruction;
        instr_v_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= '0;
      instr_s_q <= '0;
      instr_v_q <= '0;
    end else begin
      pc_q      <= pc_d;
      instr_s_q <= instr_s_d;
      instr_v_q <= instr_v_d;
    end
  end

  assign PCF           = pc_q;
  assign PCPlus8D      = pc_plus4;
  assign InstrD        = instr_s_q;
  assign InstrD_vector = instr_v_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by randomized cycles,
// all compared against a cycle-level behavioural model of the fetch rules.
module tb_fetch_stage;

  localparam int N = 24;
  localparam int MASK = (1 << N) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] ResultW = '0;
  logic [N-1:0] ExtImmE = '0;
  logic         PCSrcW = 1'b0;
  logic         BranchTakenE = 1'b0;
  logic         StallF = 1'b0;
  logic         StallD = 1'b0;
  logic         FlushD = 1'b0;
  logic [N-1:0] instruction = '0;
  logic [N-1:0] PCF, InstrD, InstrD_vector, PCPlus8D;

  int vectors = 0;
  int miscompares = 0;

  int m_pc = 0;
  int m_s  = 0;
  int m_v  = 0;

  fetch_stage #(.N(N)) dut (
    .clk(clk), .rst(rst), .ResultW(ResultW), .ExtImmE(ExtImmE),
    .PCSrcW(PCSrcW), .BranchTakenE(BranchTakenE), .StallF(StallF),
    .StallD(StallD), .FlushD(FlushD), .instruction(instruction),
    .PCF(PCF), .InstrD(InstrD), .InstrD_vector(InstrD_vector),
    .PCPlus8D(PCPlus8D)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%06h expected 0x%06h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the model by the fetch rules, then compare after the edge.
  task automatic cycle(input bit r, input bit bt, input bit ps, input bit sf, input bit sd,
                       input bit fl, input int ext, input int res, input int ins);
    rst = r; BranchTakenE = bt; PCSrcW = ps; StallF = sf; StallD = sd; FlushD = fl;
    ExtImmE = N'(ext); ResultW = N'(res); instruction = N'(ins);
    if (r) begin
      m_pc = 0; m_s = 0; m_v = 0;
    end else begin
      if (sf) m_pc = bt ? (ext & MASK) : ps ? (res & MASK) : ((m_pc + 4) & MASK);
      if (fl) begin
        m_s = 0; m_v = 0;
      end else if (sd) begin
        if (((ins >> 20) & 1) == 1) begin m_v = ins & MASK; m_s = 0; end
        else                         begin m_s = ins & MASK; m_v = 0; end
      end
    end
    @(posedge clk);
    #1;
    check_val("PCF", PCF, N'(m_pc));
    check_val("PCPlus8D", PCPlus8D, N'((m_pc + 4) & MASK));
    check_val("InstrD", InstrD, N'(m_s));
    check_val("InstrD_vector", InstrD_vector, N'(m_v));
  endtask

  initial begin
    // reset and sequential fetch
    cycle(1, 0, 0, 1, 1, 0, 0, 0, 'h0AAAAA);
    cycle(0, 0, 0, 1, 1, 0, 0, 0, 'h000011);
    cycle(0, 0, 0, 1, 1, 0, 0, 0, 'h000022);
    cycle(0, 0, 0, 1, 1, 0, 0, 0, 'h000033);
    // vector steering
    cycle(0, 0, 0, 1, 1, 0, 0, 0, 'h300000);
    cycle(0, 0, 0, 1, 1, 0, 0, 0, 'h200000);
    // redirects, including both at once
    cycle(0, 1, 0, 1, 1, 0, 'h000040, 0, 'h000044);
    cycle(0, 0, 1, 1, 1, 0, 0, 'h000100, 'h000055);
    cycle(0, 1, 1, 1, 1, 0, 'h000080, 'h000200, 'h000066);
    // stalls then resume
    cycle(0, 0, 0, 0, 1, 0, 0, 0, 'h000077);
    cycle(0, 0, 0, 0, 1, 0, 0, 0, 'h000088);
    cycle(0, 0, 0, 1, 0, 0, 0, 0, 'h123456);
    cycle(0, 0, 0, 1, 0, 0, 0, 0, 'h334455);
    cycle(0, 0, 0, 1, 1, 0, 0, 0, 'h000099);
    // flush beats load
    cycle(0, 0, 0, 1, 1, 1, 0, 0, 'hABCDEF);
    cycle(0, 0, 0, 1, 1, 0, 0, 0, 'h3ABCDE);
    cycle(0, 0, 0, 1, 1, 1, 0, 0, 'h112233);
    // wrap at top of address space
    cycle(0, 1, 0, 1, 1, 0, 'hFFFFFC, 0, 'h000001);
    cycle(0, 0, 0, 1, 1, 0, 0, 0, 'h000002);
    cycle(0, 0, 0, 1, 1, 0, 0, 0, 'h000003);
    // reset overrides a simultaneous branch
    cycle(0, 0, 0, 1, 1, 0, 0, 0, 'h100004);
    cycle(1, 1, 1, 1, 1, 0, 'h000500, 'h000600, 'h100005);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 31) == 0),
            ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 4) != 0),
            ($urandom_range(0, 4) != 0),
            ($urandom_range(0, 9) == 0),
            int'($urandom_range(0, MASK)),
            int'($urandom_range(0, MASK)),
            int'($urandom_range(0, MASK)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
